boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
Upstream feeder of the processor top's instruction-cache boot port. Accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words. Issues one active-low write strobe per word with an incrementing address. Holds boot_up high for the whole load and checks a trailing XOR checksum.

Parameters:
ADDR_W, 8, width of boot_addr; a load covers at most 2^ADDR_W words.
DATA_W, 32, width of boot_datai; fixed at 4 bytes per word.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
in_valid  in  1  in_data holds a valid byte
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte this cycle
boot_up  out  1  high while a load is in progress
boot_addr  out  ADDR_W  icache write address
boot_datai  out  DATA_W  icache write data
boot_web  out  1  icache write enable, active low
done  out  1  one-cycle pulse at end of load
err  out  1  checksum mismatch; sticky until the next accepted start

Behaviour:
- Reset is asynchronous and active-low (rst_n). Reset values: state IDLE, boot_up 0, boot_web 1, boot_addr 0, boot_datai 0, in_ready 0, done 0, err 0, all internal counters and accumulators 0.
- A byte transfers only when in_valid & in_ready are both high at the clk edge. in_ready is a Moore output: 1 in HDR, DATA and CHK, 0 otherwise.
- The FSM has five states: IDLE, HDR, DATA, WRITE, CHK.
- IDLE:
  - start=1 -> HDR.
  - On that edge: boot_up<=1, err<=0, word counter<=0, byte counter<=0, xor accumulator<=0.
  - start is ignored in every other state.
- HDR:
  - Accepted byte H sets the word count: H, or 2^ADDR_W when H==0.
  - last_addr <= H-1 modulo 2^ADDR_W. Next state DATA.
- DATA:
  - Each accepted byte shifts into the assembly register, MSB first: byte0 -> [31:24], byte3 -> [7:0].
  - Each accepted byte is XORed into the accumulator.
  - The byte counter counts 0..3. On the 4th accepted byte the counter clears and the state moves to WRITE.
- WRITE (exactly one cycle):
  - boot_web=0, boot_addr=word counter, boot_datai=assembled word; all three are registered outputs.
  - The strobe asserts in the cycle after the 4th byte is accepted (1-cycle latency).
  - Next state: CHK if word counter==last_addr; otherwise word counter+1, back to DATA.
- CHK:
  - The accepted byte is compared with the accumulator; a mismatch sets err<=1.
  - Next state IDLE. On that edge boot_up<=0 and done<=1 for one cycle.
- boot_web returns to 1 after WRITE. boot_addr and boot_datai hold their last values until the next write.
- Word counter never wraps within a load. For H==0, addresses run 0..2^ADDR_W-1 and the load ends.
- Stalls: in_valid low in any accepting state holds all state indefinitely (no timeout). Bytes presented while in_ready=0 are not consumed.
- A start that coincides with in_valid in IDLE consumes no byte; the header is taken on a later cycle.
- rst_n low mid-load: all outputs go immediately to their reset values and the partial word is discarded. Words already written are not retracted.
- Minimum throughput: 5 cycles per word (4 byte cycles + 1 WRITE cycle).

Decomposition:
- Shared package boot_pkg: state encoding (IDLE=0, HDR=1, DATA=2, WRITE=3, CHK=4, 3-bit), BOOT_BYTES=4, byte width 8.
- One natural sub-module, boot_word_asm, containing the shift register, 2-bit byte counter, xor accumulator and word_ready flag. The FSM, address counter and output registers stay in boot_loader.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> asynchronous reset values immediately; boot_web=1, boot_up=0, in_ready=0.
2. Nominal load, zero-stall stream:
   - stimulus: start; bytes 02, 11 22 33 44, AA BB CC DD, 44;
   - response: writes addr0=0x11223344, addr1=0xAABBCCDD; boot_web low exactly 2 single cycles; done pulse with boot_up falling on the same edge; err=0.
3. Bad checksum: same stream with final byte 45 -> both writes still occur; err=1 after done; err clears on the next start.
4. Full load: H=00, data words 0x00000000..0x000000FF plus correct checksum -> exactly 256 strobes, addresses 0..255 in order, no write to addr 0 after 255; err=0.
5. Handshake stress:
   - stimulus: random in_valid gaps; start pulses injected during DATA;
   - response: identical writes to scenario 2; in_ready=0 in every WRITE and IDLE cycle; no extra load is started.
6. Reset mid-load:
   - stimulus: rst_n pulsed after 2 DATA bytes; then start; bytes 01, DE AD BE EF, checksum 0x22;
   - response: single write addr0=0xDEADBEEF, no residue from the partial word; err=0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared encodings for the boot loader: FSM states and byte/word geometry.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4
  } state_t;

  localparam int BOOT_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = BOOT_BYTES * BYTE_W;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and icache boot-port output bundle of the boot loader.
interface boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              boot_up;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_datai;
  logic              boot_web;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, boot_up, boot_addr, boot_datai, boot_web, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, boot_up, boot_addr, boot_datai, boot_web, done, err
  );
endinterface

// File: rtl/boot_word_asm.sv
// Packs accepted bytes MSB-first into a word, keeps a running XOR; word_ready flags the 4th byte.
// Zero latency to word_nxt/word_ready; consumes a byte only when shift_en is high.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_nxt,
  output logic [BYTE_W-1:0] xor_acc,
  output logic              word_ready
);

  // Only the first three bytes need storage; the fourth is taken straight from byte_in.
  logic [WORD_W-BYTE_W-1:0] shreg;
  logic [1:0]               byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_cnt <= '0;
      xor_acc  <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
      xor_acc  <= '0;
    end else if (shift_en) begin
      shreg    <= {shreg[WORD_W-2*BYTE_W-1:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
      xor_acc  <= xor_acc ^ byte_in;
    end
  end

  assign word_nxt   = {shreg, byte_in};
  assign word_ready = shift_en & (byte_cnt == 2'(BOOT_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Loads a header-counted byte stream into the icache boot port, one strobe per 4 bytes, then checks an XOR byte.
// Strobe one cycle after the 4th byte; stalls on in_valid low, in_ready drops in IDLE and WRITE.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  boot_loader_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              in_ready_q;
  logic              boot_up_q;
  logic              web_q;
  logic              done_q;
  logic              err_q;

  logic              xfer;
  logic              asm_clr;
  logic              asm_shift;
  logic              word_ready;
  logic [WORD_W-1:0] asm_word;
  logic [BYTE_W-1:0] asm_xor;

  assign xfer      = bus.in_valid & in_ready_q;
  assign asm_clr   = (state == IDLE) & bus.start;
  assign asm_shift = (state == DATA) & xfer;

  boot_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (asm_clr),
    .shift_en   (asm_shift),
    .byte_in    (bus.in_data),
    .word_nxt   (asm_word),
    .xor_acc    (asm_xor),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      last_addr  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      boot_up_q  <= 1'b0;
      web_q      <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state      <= HDR;
          boot_up_q  <= 1'b1;
          err_q      <= 1'b0;
          word_cnt   <= '0;
          in_ready_q <= 1'b1;
        end
        // A zero header wraps to the top address, giving a full 2^ADDR_W-word load.
        HDR: if (xfer) begin
          last_addr <= ADDR_W'(bus.in_data) - ADDR_W'(1);
          state     <= DATA;
        end
        DATA: if (word_ready) begin
          state      <= WRITE;
          in_ready_q <= 1'b0;
          web_q      <= 1'b0;
          addr_q     <= word_cnt;
          data_q     <= DATA_W'(asm_word);
        end
        WRITE: begin
          web_q      <= 1'b1;
          in_ready_q <= 1'b1;
          if (word_cnt == last_addr) begin
            state <= CHK;
          end else begin
            word_cnt <= word_cnt + ADDR_W'(1);
            state    <= DATA;
          end
        end
        CHK: if (xfer) begin
          err_q      <= (bus.in_data != asm_xor);
          state      <= IDLE;
          boot_up_q  <= 1'b0;
          done_q     <= 1'b1;
          in_ready_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          boot_up_q  <= 1'b0;
          web_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.boot_up    = boot_up_q;
  assign bus.boot_addr  = addr_q;
  assign bus.boot_datai = data_q;
  assign bus.boot_web   = web_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: vector table, hand sequences and random loads against a stream-level model.
module tb_boot_loader;

  logic clk;
  logic rst_n;

  boot_loader_if #(.ADDR_W(8), .DATA_W(32)) bif ();

  boot_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observed writes and done pulses
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  logic        prev_up  = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bif.boot_web === 1'b0) begin
        wa_q.push_back(bif.boot_addr);
        wd_q.push_back(bif.boot_datai);
        chk("in_ready_in_write", bif.in_ready, 64'd0);
      end
      if (bif.boot_up === 1'b0)
        chk("in_ready_idle", bif.in_ready, 64'd0);
      if (bif.done === 1'b1) begin
        done_cnt++;
        chk("boot_up_at_done", bif.boot_up, 64'd0);
        chk("boot_up_before_done", prev_up, 64'd1);
      end
      prev_up = bif.boot_up;
    end else begin
      prev_up = 1'b0;
    end
  end

  // Stream-level reference model
  logic [7:0]  stream[$];
  logic [31:0] exp_w[$];
  int          exp_n;
  logic        exp_err;

  task automatic model();
    logic [7:0] x;
    x = 8'h00;
    exp_w.delete();
    exp_n = (stream[0] == 8'h00) ? 256 : int'(stream[0]);
    for (int i = 0; i < exp_n; i++) begin
      exp_w.push_back({stream[1+4*i], stream[2+4*i], stream[3+4*i], stream[4+4*i]});
      for (int k = 1; k <= 4; k++) x = x ^ stream[k+4*i];
    end
    exp_err = (stream[1+4*exp_n] != x);
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  task automatic begin_load();
    @(negedge clk);
    bif.start    = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_data  = 8'hA5;   // must not be taken as the header
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit stress);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bif.in_valid = 1'b0;
      bif.in_data  = 8'($urandom);
      bif.start    = stress ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    bif.start    = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    t = 0;
    while (bif.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", bif.in_ready, 64'd1);
  endtask

  task automatic feed_and_check(input int max_gap, input bit stress);
    int t;
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    model();
    foreach (stream[i])
      send_byte(stream[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0, stress);
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.start    = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    chk("done_count", done_cnt, 64'd1);
    chk("num_writes", wa_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < wa_q.size(); i++) begin
      chk("write_addr", wa_q[i], 64'(i));
      chk("write_data", wd_q[i], exp_w[i]);
    end
    chk("err", bif.err, exp_err);
    chk("boot_up_idle", bif.boot_up, 64'd0);
  endtask

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  ck;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h02, 32'h11223344, 32'hAABBCCDD, 8'h44, 1'b0};
    tbl[1] = '{8'h02, 32'h11223344, 32'hAABBCCDD, 8'h45, 1'b1};
    tbl[2] = '{8'h01, 32'hDEADBEEF, 32'h0,        8'h22, 1'b0};
    tbl[3] = '{8'h02, 32'h01020304, 32'h05060708, 8'h08, 1'b0};
    tbl[4] = '{8'h01, 32'hFFFFFFFF, 32'h0,        8'h00, 1'b0};
    tbl[5] = '{8'h01, 32'h00000001, 32'h0,        8'h00, 1'b1};

    rst_n        = 1'b0;
    bif.start    = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_boot_web", bif.boot_web, 64'd1);
    chk("rst_boot_up", bif.boot_up, 64'd0);
    chk("rst_in_ready", bif.in_ready, 64'd0);
    chk("rst_done", bif.done, 64'd0);
    chk("rst_err", bif.err, 64'd0);
    chk("rst_addr", bif.boot_addr, 64'd0);
    chk("rst_datai", bif.boot_datai, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table, zero-stall streams
    for (int v = 0; v < 6; v++) begin
      stream.delete();
      stream.push_back(tbl[v].hdr);
      push_word(tbl[v].w0);
      if (tbl[v].hdr == 8'h02) push_word(tbl[v].w1);
      stream.push_back(tbl[v].ck);
      begin_load();
      feed_and_check(0, 1'b0);
      chk("table_err", bif.err, tbl[v].exp_err);
    end

    // err is sticky after a bad checksum and clears on the next accepted start
    stream.delete();
    stream.push_back(8'h02);
    push_word(32'h11223344);
    push_word(32'hAABBCCDD);
    stream.push_back(8'h45);
    begin_load();
    feed_and_check(0, 1'b0);
    repeat (5) @(negedge clk);
    chk("err_sticky", bif.err, 64'd1);
    begin_load();
    @(negedge clk);
    bif.start    = 1'b0;
    bif.in_valid = 1'b0;
    chk("err_clear_on_start", bif.err, 64'd0);
    chk("boot_up_after_start", bif.boot_up, 64'd1);
    stream[stream.size()-1] = 8'h44;
    feed_and_check(0, 1'b0);

    // Full 256-word load
    stream.delete();
    stream.push_back(8'h00);
    for (int i = 0; i < 256; i++) push_word(32'(i));
    stream.push_back(8'h00);
    begin_load();
    feed_and_check(0, 1'b0);
    chk("full_load_err", bif.err, 64'd0);

    // Handshake stress: random gaps and stray start pulses mid-load
    for (int r = 0; r < 3; r++) begin
      stream.delete();
      stream.push_back(8'h02);
      push_word(32'h11223344);
      push_word(32'hAABBCCDD);
      stream.push_back(8'h44);
      begin_load();
      feed_and_check(3, 1'b1);
      repeat (20) @(negedge clk);
      chk("stress_no_restart", bif.boot_up, 64'd0);
      chk("stress_no_extra_write", wa_q.size(), 64'd2);
    end

    // Random loads, correct or corrupted checksum
    for (int r = 0; r < 8; r++) begin
      logic [7:0] x;
      int         n;
      n = $urandom_range(1, 5);
      x = 8'h00;
      stream.delete();
      stream.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = $urandom;
        push_word(w);
        x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      end
      if ($urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
      stream.push_back(x);
      begin_load();
      feed_and_check(2, 1'b0);
    end

    // Asynchronous reset mid-load discards the partial word
    begin_load();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_boot_web", bif.boot_web, 64'd1);
    chk("arst_boot_up", bif.boot_up, 64'd0);
    chk("arst_in_ready", bif.in_ready, 64'd0);
    chk("arst_addr", bif.boot_addr, 64'd0);
    chk("arst_datai", bif.boot_datai, 64'd0);
    chk("arst_err", bif.err, 64'd0);
    bif.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stream.delete();
    stream.push_back(8'h01);
    push_word(32'hDEADBEEF);
    stream.push_back(8'h22);
    begin_load();
    feed_and_check(0, 1'b0);
    chk("post_reset_err", bif.err, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
